// File: rtl/aes_pkg.sv
// Shared AES definitions: key-expansion FSM encoding, rcon reset value and
// the small word/byte helpers used by both key schedule and data path.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAST = 2'd2
    } state_t;

    localparam logic [7:0] RCON_RESET = 8'h01;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Computed AES S-box: GF(2^8) inverse through the GF(2^4) subfield
// (Itoh-Tsujii), followed by the AES affine transform. No lookup tables.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    logic [7:0] x2, x4, x8, x16;
    logic [7:0] a17, a2, a4, a8, a_inv, inv;

    // x^17 is the norm into GF(2^4); its inverse there is (x^17)^14, and
    // x^-1 = x^16 * (x^17)^-1. Zero maps to zero automatically.
    assign x2    = gf_mul(din, din);
    assign x4    = gf_mul(x2, x2);
    assign x8    = gf_mul(x4, x4);
    assign x16   = gf_mul(x8, x8);
    assign a17   = gf_mul(x16, din);
    assign a2    = gf_mul(a17, a17);
    assign a4    = gf_mul(a2, a2);
    assign a8    = gf_mul(a4, a4);
    assign a_inv = gf_mul(gf_mul(a2, a4), a8);
    assign inv   = gf_mul(x16, a_inv);
    assign dout  = affine(inv);

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key expansion: emits round keys 0..10 one per accepted transfer
// over a valid/ready handshake, computing each next key on the fly.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] rk,
    output logic [3:0]   rk_round,
    output logic         busy
);

    state_t state, state_next;
    logic [7:0]  rcon;
    logic        xfer, load, advance, finish;
    logic [31:0] w0, w1, w2, w3, rot, sub;
    logic [31:0] n0, n1, n2, n3;

    assign xfer = rk_valid & rk_ready;
    assign {w0, w1, w2, w3} = rk;
    assign rot = rot_word(w3);

    for (genvar i = 0; i < 4; i++) begin : g_sub
        aes_sbox u_sbox (
            .din  (rot[8*i +: 8]),
            .dout (sub[8*i +: 8])
        );
    end

    assign n0 = w0 ^ sub ^ {rcon, 24'h000000};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    advance = 1'b1;
                    if (rk_round == 4'(NR - 1)) state_next = ST_LAST;
                end
            end
            ST_LAST: begin
                if (xfer) begin
                    finish     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs are held unchanged unless a load, advance or finish fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk       <= '0;
            rk_round <= '0;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            rcon     <= RCON_RESET;
        end else if (load) begin
            rk       <= key_in;
            rk_round <= '0;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            rcon     <= RCON_RESET;
        end else if (advance) begin
            rk       <= {n0, n1, n2, n3};
            rk_round <= rk_round + 4'd1;
            rcon     <= xtime(rcon);
        end else if (finish) begin
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            rcon     <= xtime(rcon);
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand using the FIPS-197 key schedules.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]   round;
        logic [127:0] key;
        bit           chk_key;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    localparam logic [127:0] KEY_A   = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] KEY_B   = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] KEY_B10 = 128'h13111d7f_e3944a17_f307a78b_4d2b30c5;

    logic [127:0] sched_a [11] = '{
        128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
        128'ha0fafe17_88542cb1_23a33939_2a6c7605,
        128'hf2c295f2_7a96b943_5935807a_7359f67f,
        128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
        128'hef44a541_a8525b7f_b671253b_db0bad00,
        128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
        128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
        128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
        128'head27321_b58dbad2_312bf560_7f8d292f,
        128'hac7766f3_19fadc21_28d12941_575c006e,
        128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6
    };

    aes_key_expand #(.NR(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .rk_ready (rk_ready),
        .rk_valid (rk_valid),
        .rk       (rk),
        .rk_round (rk_round),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_a();
        for (int r = 0; r < 11; r++) sb.push_back('{4'(r), sched_a[r], 1'b1});
    endtask

    task automatic push_b();
        for (int r = 0; r < 11; r++)
            sb.push_back('{4'(r), (r == 0) ? KEY_B : KEY_B10, (r == 0 || r == 10)});
    endtask

    // Called at #1 after a rising edge; start is seen on the next edge.
    task automatic do_start(input logic [127:0] k, input bit which_b);
        start  = 1'b1;
        key_in = k;
        if (which_b) push_b();
        else         push_a();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_round(input int r);
        int n;
        n = 0;
        while (!(rk_valid && rk_round == 4'(r)) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL wait_round%0d: got timeout want round %0d", r, r);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 1000) begin
            total++;
            bad++;
            $display("FAIL wait_idle: got busy after %0d cycles want idle", n);
        end
    endtask

    // Monitor: a transfer happens on the next edge whenever valid&&ready here.
    logic         stalled = 1'b0;
    logic [127:0] held_rk;
    logic [3:0]   held_round;

    always @(negedge clk) begin
        if (rst_n && rk_valid) begin
            if (stalled) begin
                check("stall_rk", rk, held_rk);
                check("stall_round", 128'(rk_round), 128'(held_round));
            end
            if (rk_ready) begin
                stalled = 1'b0;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_key: got round %0d want none", rk_round);
                end else begin
                    e = sb.pop_front();
                    check("round_idx", 128'(rk_round), 128'(e.round));
                    if (e.chk_key) check($sformatf("rk_r%0d", e.round), rk, e.key);
                end
            end else begin
                stalled    = 1'b1;
                held_rk    = rk;
                held_round = rk_round;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        start    = 1'b0;
        rk_ready = 1'b1;
        key_in   = '0;
        #2;
        check("rst_valid", 128'(rk_valid), 128'(0));
        check("rst_busy",  128'(busy),     128'(0));
        check("rst_rk",    rk,             128'(0));
        check("rst_round", 128'(rk_round), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full-throughput run: 11 consecutive valid cycles.
        do_start(KEY_A, 1'b0);
        n = 0;
        while (busy && rk_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("valid_cycles", 128'(n), 128'(11));
        check("idle_valid", 128'(rk_valid), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        check("rk_hold_idle", rk, sched_a[10]);

        // Random backpressure.
        start    = 1'b1;
        key_in   = KEY_A;
        push_a();
        rk_ready = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (busy && n < 600) begin
            rk_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
        rk_ready = 1'b1;
        check("random_done", 128'(busy), 128'(0));

        // Start while running is ignored.
        do_start(KEY_A, 1'b0);
        wait_round(4);
        start  = 1'b1;
        key_in = '1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Asynchronous reset mid-expansion, then a fresh key.
        do_start(KEY_A, 1'b0);
        wait_round(6);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 128'(rk_valid), 128'(0));
        check("arst_busy",  128'(busy),     128'(0));
        check("arst_rk",    rk,             128'(0));
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_start(KEY_B, 1'b1);
        wait_idle();

        // Start during the round-10 transfer is ignored; one cycle later it is taken.
        do_start(KEY_A, 1'b0);
        wait_round(10);
        start  = 1'b1;
        key_in = KEY_B;
        @(posedge clk);
        #1;
        check("late_start_valid", 128'(rk_valid), 128'(0));
        check("late_start_busy",  128'(busy),     128'(0));
        push_b();
        @(posedge clk);
        #1;
        start = 1'b0;
        check("next_start_valid", 128'(rk_valid), 128'(1));
        check("next_start_round", 128'(rk_round), 128'(0));
        wait_idle();

        @(posedge clk);
        #1;
        check("sb_empty", 128'(sb.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 Parameter: NR, 10, number of AES rounds; only 10 (AES-128) is supported.
REQ-002 Port: clk  in  1  single clock, rising-edge; all state is clocked by clk.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: start  in  1  one-cycle request to begin a new expansion; sampled only in IDLE.
REQ-005 Port: key_in  in  128  cipher key, word 0 in bits 127:96; sampled on an accepted start.
REQ-006 Port: rk_ready  in  1  consumer (computed AES core) accepts the current round key.
REQ-007 Port: rk_valid  out  1  rk and rk_round hold a valid round key.
REQ-008 Port: rk  out  128  round key, word 0 in bits 127:96.
REQ-009 Port: rk_round  out  4  index of the round key on rk, 0..10.
REQ-010 Port: busy  out  1  high from an accepted start until the round-10 key transfers.

Function
REQ-011 The block SHALL have the states IDLE, RUN and LAST.
REQ-012 In IDLE with start=1, the block SHALL load key_in into rk and set rk_round=0 and rk_valid=1 on the next edge, then go to RUN.
REQ-013 A transfer SHALL occur on any edge where rk_valid=1 and rk_ready=1; rk, rk_round and rk_valid SHALL hold stable while rk_valid=1 and rk_ready=0.
REQ-014 On a transfer in RUN, the block SHALL replace rk with the next round key on the same edge, increment rk_round and keep rk_valid=1, for one-key-per-cycle throughput.
REQ-015 The next key SHALL be computed as w0'=w0^SubWord(RotWord(w3))^{rcon,24'h0}, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
REQ-016 rcon SHALL start at 8'h01 for round 1 and advance by xtime (shift left 1, XOR 8'h1b when bit 7 was set) after each transfer; rounds 9 and 10 SHALL therefore use 8'h1b and 8'h36.
REQ-017 When rk_round reaches 10, the state SHALL be LAST; the transfer of the round-10 key SHALL clear rk_valid and busy and return the block to IDLE.
REQ-018 start SHALL be ignored in RUN and LAST; there is no abort input.
REQ-019 start asserted in the same cycle that the round-10 key transfers SHALL be ignored; a new start is accepted from the following cycle.
REQ-020 rk_ready held low SHALL stall indefinitely with no loss or corruption of state.
REQ-021 rk SHALL hold its last value in IDLE; consumers use it only while rk_valid=1.

Reset
REQ-022 Asserting rst_n low SHALL immediately force state=IDLE, rk_valid=0, busy=0, rk=0, rk_round=0 and rcon=8'h01, including in the middle of an expansion.
REQ-023 After rst_n deasserts, the first accepted start SHALL be on the first rising edge at which start=1.

Structure
REQ-024 The state encoding, the rcon reset value, and the xtime and RotWord functions SHALL be placed in a shared package, aes_pkg.
REQ-025 SubWord SHALL use four instances of one combinational sub-module, aes_sbox (computed composite-field S-box, 8-in/8-out, no tables), shared with the AES data path.
REQ-026 The design SHALL use no latches, and all outputs SHALL be driven directly from registers.

Verification
REQ-027 Hold rk_ready=1, key_in=2b7e1516_28aed2a6_abf71588_09cf4f3c, pulse start -> round 0 equals the key, round 1 = a0fafe17_88542cb1_23a33939_2a6c7605, round 10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6, with 11 consecutive valid cycles.
REQ-028 Same key, with rk_ready toggled randomly -> identical 11-key sequence, and rk stable during every stall.
REQ-029 Pulse start again while rk_round=4 -> the start is ignored and the sequence completes unchanged.
REQ-030 Drive rst_n low while rk_round=6 -> rk_valid=0, busy=0 and rk=0 immediately; a subsequent start with key 000102..0f gives a round-10 key of 13111d7f_e3944a17_f307a78b_4d2b30c5.
REQ-031 Pulse start in the cycle of the round-10 transfer -> no new expansion; start one cycle later -> rk_round=0 is valid on the next edge.
